// File: rtl/cont_dato_mod_if.sv
// Bus bundle for one clock/calendar field counter: the controls from the
// button/timekeeping side and the count, BCD and cascade outputs.
interface cont_dato_mod_if #(
   parameter int WIDTH = 5,
   parameter int OUT_W = 7
);
   logic             en;
   logic             aum;
   logic             dism;
   logic             tick;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [OUT_W-1:0] dat_sal;
   logic [7:0]       bcd_sal;
   logic             carry;
   logic             borrow;

   // Master drives the controls and observes the field.
   modport master (
      output en, aum, dism, tick, load, load_val,
      input  dat_sal, bcd_sal, carry, borrow
   );

   // Slave is the counter itself.
   modport slave (
      input  en, aum, dism, tick, load, load_val,
      output dat_sal, bcd_sal, carry, borrow
   );
endinterface

// File: rtl/cont_dato_mod.sv
// Generic MIN_VAL..MAX_VAL up/down wrap counter for one clock/calendar field.
// Buttons step on their rising edge and optionally auto-repeat while held;
// tick adds one count for timekeeping or cascading; load jumps to a clamped
// value. carry/borrow pulse for one cycle after a wrap so the next field can
// follow, and bcd_sal feeds the display.
module cont_dato_mod #(
   parameter int WIDTH    = 5,
   parameter int MIN_VAL  = 0,
   parameter int MAX_VAL  = 23,
   parameter int OUT_W    = 7,
   parameter int HOLD_CYC = 0,
   parameter int REP_CYC  = 1
) (
   input  logic            clk,
   input  logic            reset,
   cont_dato_mod_if.slave  bus
);

   localparam int CW = $clog2(HOLD_CYC + REP_CYC + 2);
   localparam int DW = (WIDTH > 7) ? WIDTH : 7;
   localparam bit REP_EN = (HOLD_CYC > 0);

   localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_VAL);
   localparam logic [CW-1:0]    HOLD_W    = CW'(HOLD_CYC);
   localparam logic [CW-1:0]    LAST_W    = CW'(HOLD_CYC + REP_CYC);
   localparam logic [CW-1:0]    RESTART_W = CW'(HOLD_CYC + 1);

   logic [WIDTH-1:0] r_dat;
   logic             r_carry;
   logic             r_borrow;
   logic             r_aumQ;
   logic             r_dismQ;
   logic [CW-1:0]    r_upCnt;
   logic [CW-1:0]    r_dnCnt;

   logic [CW-1:0]    w_upCntNxt;
   logic [CW-1:0]    w_dnCntNxt;
   logic             w_upEdge;
   logic             w_dnEdge;
   logic             w_upRep;
   logic             w_dnRep;
   logic             w_upStep;
   logic             w_dnStep;
   logic             w_inc;
   logic             w_dec;
   logic [DW-1:0]    w_datExt;
   logic [3:0]       w_tens;
   logic [3:0]       w_units;

   // A press is the cycle the level goes high while the field is enabled.
   // The hold counter is nonzero only while the same press is still being
   // held; it reads HOLD_CYC on the first repeat cycle and LAST_W on every
   // following one, so both values produce a repeat step.
   assign w_upEdge = bus.en & bus.aum & ~r_aumQ;
   assign w_dnEdge = bus.en & bus.dism & ~r_dismQ;
   assign w_upRep  = REP_EN & bus.en & bus.aum & r_aumQ & ~bus.dism &
                     ((r_upCnt == HOLD_W) | (r_upCnt == LAST_W));
   assign w_dnRep  = REP_EN & bus.en & bus.dism & r_dismQ & ~bus.aum &
                     ((r_dnCnt == HOLD_W) | (r_dnCnt == LAST_W));
   assign w_upStep = w_upEdge | w_upRep;
   assign w_dnStep = w_dnEdge | w_dnRep;

   // A tick and an up step in the same cycle merge into one increment.
   assign w_inc = w_upStep | (bus.en & bus.tick);
   assign w_dec = w_dnStep;

   // Next hold-counter values: restart at 1 on a fresh press, advance while
   // held, fold back after each repeat, and drop to idle on release, on a
   // disabled field or when both buttons are down.
   always_comb begin
      w_upCntNxt = '0;
      w_dnCntNxt = '0;
      if (REP_EN && bus.en && bus.aum && !bus.dism) begin
         if (!r_aumQ)
            w_upCntNxt = CW'(1);
         else if (r_upCnt == LAST_W)
            w_upCntNxt = RESTART_W;
         else if (r_upCnt != '0)
            w_upCntNxt = r_upCnt + CW'(1);
      end
      if (REP_EN && bus.en && bus.dism && !bus.aum) begin
         if (!r_dismQ)
            w_dnCntNxt = CW'(1);
         else if (r_dnCnt == LAST_W)
            w_dnCntNxt = RESTART_W;
         else if (r_dnCnt != '0)
            w_dnCntNxt = r_dnCnt + CW'(1);
      end
   end

   // Button history and hold counters; the history tracks the levels even
   // with the field disabled so re-enabling mid-press never looks like a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_aumQ  <= 1'b0;
         r_dismQ <= 1'b0;
         r_upCnt <= '0;
         r_dnCnt <= '0;
      end else begin
         r_aumQ  <= bus.aum;
         r_dismQ <= bus.dism;
         r_upCnt <= w_upCntNxt;
         r_dnCnt <= w_dnCntNxt;
      end
   end

   // Count register with load, wrap and the one-cycle cascade pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dat    <= MIN_W;
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_carry  <= 1'b0;
         r_borrow <= 1'b0;
         if (bus.load) begin
            if (bus.load_val <= MIN_W)
               r_dat <= MIN_W;
            else if (bus.load_val >= MAX_W)
               r_dat <= MAX_W;
            else
               r_dat <= bus.load_val;
         end else if (bus.en) begin
            if (w_inc && !w_dec) begin
               if (r_dat == MAX_W) begin
                  r_dat   <= MIN_W;
                  r_carry <= 1'b1;
               end else begin
                  r_dat <= r_dat + WIDTH'(1);
               end
            end else if (w_dec && !w_inc) begin
               if (r_dat == MIN_W) begin
                  r_dat    <= MAX_W;
                  r_borrow <= 1'b1;
               end else begin
                  r_dat <= r_dat - WIDTH'(1);
               end
            end
         end
      end
   end

   // Display path: split the count into decimal digits.
   assign w_datExt = DW'(r_dat);
   assign w_tens   = 4'(w_datExt / DW'(10));
   assign w_units  = 4'(w_datExt % DW'(10));

   assign bus.dat_sal = OUT_W'(r_dat);
   assign bus.bcd_sal = {w_tens, w_units};
   assign bus.carry   = r_carry;
   assign bus.borrow  = r_borrow;

endmodule

// File: tb/tb_cont_dato_mod.sv
// Directed bench for cont_dato_mod: three instances cover the default 0..23
// field, a 1..12 field and a 0..23 field with hold-to-repeat (4 then every 2).
// Inputs change just after the falling edge and outputs are sampled on the
// falling edge, half a period away from the active edge.
module tb_cont_dato_mod;

   logic clk;
   logic reset;

   int compared   = 0;
   int mismatched = 0;

   cont_dato_mod_if #(.WIDTH(5), .OUT_W(7)) ifA ();
   cont_dato_mod_if #(.WIDTH(4), .OUT_W(7)) ifB ();
   cont_dato_mod_if #(.WIDTH(5), .OUT_W(7)) ifC ();

   cont_dato_mod #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .OUT_W(7),
                   .HOLD_CYC(0), .REP_CYC(1))
      dutA (.clk(clk), .reset(reset), .bus(ifA));

   cont_dato_mod #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .OUT_W(7),
                   .HOLD_CYC(0), .REP_CYC(1))
      dutB (.clk(clk), .reset(reset), .bus(ifB));

   cont_dato_mod #(.WIDTH(5), .MIN_VAL(0), .MAX_VAL(23), .OUT_W(7),
                   .HOLD_CYC(4), .REP_CYC(2))
      dutC (.clk(clk), .reset(reset), .bus(ifC));

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advance the given number of clock cycles, ending on a falling edge.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) @(negedge clk);
   endtask

   // Expected count of instance C after each held cycle (steps at 0,4,6,8).
   int holdTbl [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

   initial begin
      reset = 1'b0;
      ifA.en = 1'b1; ifA.aum = 1'b0; ifA.dism = 1'b0; ifA.tick = 1'b0;
      ifA.load = 1'b0; ifA.load_val = '0;
      ifB.en = 1'b1; ifB.aum = 1'b0; ifB.dism = 1'b0; ifB.tick = 1'b0;
      ifB.load = 1'b0; ifB.load_val = '0;
      ifC.en = 1'b1; ifC.aum = 1'b0; ifC.dism = 1'b0; ifC.tick = 1'b0;
      ifC.load = 1'b0; ifC.load_val = '0;

      // Reset state.
      applyStimulus(2);
      checkOutput("rstA_dat", int'(ifA.dat_sal), 0);
      checkOutput("rstA_carry", int'(ifA.carry), 0);
      checkOutput("rstA_borrow", int'(ifA.borrow), 0);
      checkOutput("rstB_dat", int'(ifB.dat_sal), 1);
      checkOutput("rstC_dat", int'(ifC.dat_sal), 0);
      reset = 1'b1;
      applyStimulus(1);

      // Up-count through the full range with a wrap at 23.
      for (int i = 1; i <= 24; i++) begin
         ifA.aum = 1'b1;
         applyStimulus(1);
         checkOutput($sformatf("upA_dat%0d", i), int'(ifA.dat_sal), i % 24);
         checkOutput($sformatf("upA_carry%0d", i), int'(ifA.carry), (i == 24) ? 1 : 0);
         if (i == 23) checkOutput("upA_bcd23", int'(ifA.bcd_sal), 'h23);
         ifA.aum = 1'b0;
         applyStimulus(1);
      end
      checkOutput("upA_carryOff", int'(ifA.carry), 0);

      // 1..12 field: borrow on the down-wrap, then a plain decrement.
      ifB.dism = 1'b1;
      applyStimulus(1);
      checkOutput("dnB_dat12", int'(ifB.dat_sal), 12);
      checkOutput("dnB_borrow1", int'(ifB.borrow), 1);
      checkOutput("dnB_bcd12", int'(ifB.bcd_sal), 'h12);
      ifB.dism = 1'b0;
      applyStimulus(1);
      checkOutput("dnB_borrowOff", int'(ifB.borrow), 0);
      ifB.dism = 1'b1;
      applyStimulus(1);
      checkOutput("dnB_dat11", int'(ifB.dat_sal), 11);
      checkOutput("dnB_borrow0", int'(ifB.borrow), 0);
      ifB.dism = 1'b0;
      applyStimulus(1);

      // Hold-to-repeat: 10 held cycles, then one fresh press.
      ifC.aum = 1'b1;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("holdC_cyc%0d", k), int'(ifC.dat_sal), holdTbl[k]);
      end
      ifC.aum = 1'b0;
      applyStimulus(1);
      checkOutput("holdC_release", int'(ifC.dat_sal), 4);
      ifC.aum = 1'b1;
      applyStimulus(1);
      checkOutput("holdC_press", int'(ifC.dat_sal), 5);
      ifC.aum = 1'b0;
      applyStimulus(1);

      // Disabled field ignores buttons and tick; load still applies, clamped.
      ifA.en = 1'b0;
      ifA.aum = 1'b1; ifA.tick = 1'b1;
      applyStimulus(1);
      ifA.aum = 1'b0; ifA.tick = 1'b0;
      checkOutput("enA_hold", int'(ifA.dat_sal), 0);
      ifA.load = 1'b1; ifA.load_val = 5'd30;
      ifB.load = 1'b1; ifB.load_val = 4'd0;
      applyStimulus(1);
      checkOutput("ldA_clampHi", int'(ifA.dat_sal), 23);
      checkOutput("ldA_carry", int'(ifA.carry), 0);
      checkOutput("ldB_clampLo", int'(ifB.dat_sal), 1);
      checkOutput("ldB_borrow", int'(ifB.borrow), 0);
      ifA.load = 1'b0; ifB.load = 1'b0;
      ifA.en = 1'b1;
      applyStimulus(1);

      // Tick and a press together at 23 make one wrap.
      ifA.tick = 1'b1; ifA.aum = 1'b1;
      applyStimulus(1);
      checkOutput("tkA_wrap", int'(ifA.dat_sal), 0);
      checkOutput("tkA_carry", int'(ifA.carry), 1);
      ifA.tick = 1'b0; ifA.aum = 1'b0;
      applyStimulus(1);
      checkOutput("tkA_carryOff", int'(ifA.carry), 0);

      // Simultaneous up and down presses cancel.
      ifA.aum = 1'b1; ifA.dism = 1'b1;
      applyStimulus(1);
      checkOutput("bothA_dat", int'(ifA.dat_sal), 0);
      checkOutput("bothA_borrow", int'(ifA.borrow), 0);
      ifA.aum = 1'b0; ifA.dism = 1'b0;
      applyStimulus(1);
      ifA.tick = 1'b1;
      applyStimulus(1);
      checkOutput("tkA_step", int'(ifA.dat_sal), 1);
      ifA.tick = 1'b0;

      // Load 17, then a short asynchronous reset pulse mid-count while C's
      // up button is held across it.
      ifA.load = 1'b1; ifA.load_val = 5'd17;
      ifC.aum = 1'b1;
      applyStimulus(1);
      ifA.load = 1'b0;
      checkOutput("ldA_17", int'(ifA.dat_sal), 17);
      checkOutput("ldA_bcd17", int'(ifA.bcd_sal), 'h17);
      checkOutput("pressC_6", int'(ifC.dat_sal), 6);
      #2 reset = 1'b0;
      #1;
      checkOutput("arstA_dat", int'(ifA.dat_sal), 0);
      checkOutput("arstA_carry", int'(ifA.carry), 0);
      checkOutput("arstB_dat", int'(ifB.dat_sal), 1);
      checkOutput("arstC_dat", int'(ifC.dat_sal), 0);
      #1 reset = 1'b1;
      applyStimulus(1);
      checkOutput("arstC_repress", int'(ifC.dat_sal), 1);
      checkOutput("arstA_stay", int'(ifA.dat_sal), 0);
      ifC.aum = 1'b0;
      applyStimulus(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
